// File: rtl/sd_dat_pkg.sv
// Shared state encoding and CRC16 constants for the SD DAT-line deserializer.
package sd_dat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC,
    ENDB
  } state_e;

  localparam int unsigned       CRC_LEN    = 16;
  localparam logic [CRC_LEN-1:0] CRC16_POLY = 16'h1021;

  // One serial step of x^16+x^12+x^5+1, MSB-first.
  function automatic logic [CRC_LEN-1:0] crc16_step(input logic [CRC_LEN-1:0] crc,
                                                     input logic               bit_in);
    logic fb;
    fb = bit_in ^ crc[CRC_LEN-1];
    return {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// Bit-serial CRC16 accumulator for one DAT lane, with synchronous clear and step enable.
module sd_crc16
  import sd_dat_pkg::*;
(
  input  logic               sd_clock,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic               bit_i,
  output logic [CRC_LEN-1:0] crc_o
);

  logic [CRC_LEN-1:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i)       crc_d = '0;
    else if (enable_i) crc_d = crc16_step(crc_q, bit_i);
  end

  always_ff @(posedge sd_clock) begin
    if (reset) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_dat_deserializer.sv
// SD card DAT-line block receiver: start bit, data, per-lane CRC16, end bit, in 1- or 4-lane mode.
// Define SD_DAT_CRC_EN to build the per-lane CRC checkers; otherwise crc_err is tied low.
module sd_dat_deserializer
  import sd_dat_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int LANES       = 4,
  parameter int BLOCK_BYTES = 512
) (
  input  logic              sd_clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              bus_wide,
  input  logic [LANES-1:0]  dat,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              busy,
  output logic              complete,
  output logic              crc_err,
  output logic              end_err
);

  localparam int NARROW_CYCLES = BLOCK_BYTES * 8;
  localparam int WIDE_CYCLES   = BLOCK_BYTES * 2;
  localparam int MAX_CNT       = (NARROW_CYCLES > int'(CRC_LEN)) ? NARROW_CYCLES : int'(CRC_LEN);
  localparam int CNT_W         = $clog2(MAX_CNT);
  localparam int FILL_W        = $clog2(WORD_W + 1);

  logic [3:0] dat4;
  logic       wide_sel;

  if (LANES == 4) begin : g_four
    assign dat4     = dat;
    assign wide_sel = bus_wide;
  end else begin : g_one
    assign dat4     = {3'b000, dat[0]};
    assign wide_sel = 1'b0;
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, data_last;
  logic [FILL_W-1:0] fill_q, fill_d, fill_next, fill_step;
  logic [WORD_W-1:0] shift_q, shift_d, shift_next, word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic              busy_q, busy_d;
  logic              complete_q, complete_d;
  logic              end_err_q, end_err_d;
  logic              wide_q, wide_d;
  logic              start_bit, end_bad, crc_bad;

  assign start_bit  = wide_sel ? (dat4 == 4'h0) : ~dat4[0];
  assign end_bad    = wide_q ? (dat4 != 4'hF) : ~dat4[0];
  assign data_last  = wide_q ? CNT_W'(WIDE_CYCLES - 1) : CNT_W'(NARROW_CYCLES - 1);
  assign fill_step  = wide_q ? FILL_W'(4) : FILL_W'(1);
  assign fill_next  = fill_q + fill_step;
  // dat[3] carries the most significant bit of each wide-mode nibble.
  assign shift_next = wide_q ? ((shift_q << 4) | WORD_W'(dat4))
                             : ((shift_q << 1) | WORD_W'(dat4[0]));

`ifdef SD_DAT_CRC_EN
  logic [CRC_LEN-1:0] lane_crc [LANES];
  logic               crc_clear, crc_run;
  logic               crc_err_q, crc_err_d;

  assign crc_clear = (state_q == IDLE);
  assign crc_run   = enable && ((state_q == DATA) || (state_q == CRC));

  for (genvar l = 0; l < LANES; l++) begin : g_crc
    sd_crc16 u_crc (
      .sd_clock (sd_clock),
      .reset    (reset),
      .clear_i  (crc_clear),
      .enable_i (crc_run),
      .bit_i    (dat4[l]),
      .crc_o    (lane_crc[l])
    );
  end

  // Received CRC bits are fed through the same register, so a good lane leaves a zero residue.
  always_comb begin
    crc_bad = (lane_crc[0] != '0);
    for (int l = 1; l < LANES; l++) begin
      if (wide_q && (lane_crc[l] != '0)) crc_bad = 1'b1;
    end
  end

  assign crc_err = crc_err_q;
`else
  assign crc_bad = 1'b0;
  assign crc_err = 1'b0;
`endif

  // NOTE: every next-state signal gets its default first, so no path through the case can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    shift_d      = shift_q;
    word_d       = word_q;
    wide_d       = wide_q;
    busy_d       = busy_q;
    end_err_d    = end_err_q;
    word_valid_d = 1'b0;
    complete_d   = 1'b0;
`ifdef SD_DAT_CRC_EN
    crc_err_d    = crc_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (enable && start_bit) begin
          state_d   = DATA;
          busy_d    = 1'b1;
          wide_d    = wide_sel;
          cnt_d     = '0;
          fill_d    = '0;
          end_err_d = 1'b0;
`ifdef SD_DAT_CRC_EN
          crc_err_d = 1'b0;
`endif
        end
      end
      DATA: begin
        shift_d = shift_next;
        if (fill_next == FILL_W'(WORD_W)) begin
          word_d       = shift_next;
          word_valid_d = 1'b1;
          fill_d       = '0;
        end else begin
          fill_d = fill_next;
        end
        if (cnt_q == data_last) begin
          state_d = CRC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CRC: begin
        if (cnt_q == CNT_W'(CRC_LEN - 1)) begin
          state_d = ENDB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ENDB: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        complete_d = 1'b1;
        end_err_d  = end_bad;
`ifdef SD_DAT_CRC_EN
        crc_err_d  = crc_bad;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Abort: drop the block silently, leaving the last word and status flags as they were.
    if ((state_q != IDLE) && !enable) begin
      state_d      = IDLE;
      busy_d       = 1'b0;
      cnt_d        = '0;
      fill_d       = '0;
      word_d       = word_q;
      word_valid_d = 1'b0;
      complete_d   = 1'b0;
      end_err_d    = end_err_q;
`ifdef SD_DAT_CRC_EN
      crc_err_d    = crc_err_q;
`endif
    end
  end

  // NOTE: state is updated only with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fill_q       <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      wide_q       <= 1'b0;
      busy_q       <= 1'b0;
      end_err_q    <= 1'b0;
      word_valid_q <= 1'b0;
      complete_q   <= 1'b0;
`ifdef SD_DAT_CRC_EN
      crc_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      wide_q       <= wide_d;
      busy_q       <= busy_d;
      end_err_q    <= end_err_d;
      word_valid_q <= word_valid_d;
      complete_q   <= complete_d;
`ifdef SD_DAT_CRC_EN
      crc_err_q    <= crc_err_d;
`endif
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;
  assign complete   = complete_q;
  assign end_err    = end_err_q;

endmodule

// File: tb/tb_sd_dat_deserializer.sv
// Self-checking bench: builds SD DAT block waveforms from byte data and compares against expected words and status.
module tb_sd_dat_deserializer;

  logic sd_clock = 1'b0;
  always #5 sd_clock = ~sd_clock;

  logic       reset    = 1'b1;
  logic       bus_wide = 1'b0;
  logic       en_s     = 1'b0;
  logic       en_b     = 1'b0;
  logic [3:0] dat      = 4'hF;

  logic [31:0] word_s, word_b;
  logic        wv_s, busy_s, comp_s, crce_s, ende_s;
  logic        wv_b, busy_b, comp_b, crce_b, ende_b;

  sd_dat_deserializer #(.WORD_W(32), .LANES(4), .BLOCK_BYTES(4)) dut_small (
    .sd_clock   (sd_clock),
    .reset      (reset),
    .enable     (en_s),
    .bus_wide   (bus_wide),
    .dat        (dat),
    .word       (word_s),
    .word_valid (wv_s),
    .busy       (busy_s),
    .complete   (comp_s),
    .crc_err    (crce_s),
    .end_err    (ende_s)
  );

  sd_dat_deserializer #(.WORD_W(32), .LANES(4), .BLOCK_BYTES(512)) dut_big (
    .sd_clock   (sd_clock),
    .reset      (reset),
    .enable     (en_b),
    .bus_wide   (bus_wide),
    .dat        (dat),
    .word       (word_b),
    .word_valid (wv_b),
    .busy       (busy_b),
    .complete   (comp_b),
    .crc_err    (crce_b),
    .end_err    (ende_b)
  );

  int errors = 0;
  int checks = 0;

  byte unsigned blk [512];
  logic [3:0]   seq [$];

  // Bit b of the block payload, bytes sent MSB first.
  function automatic bit data_bit(input int b);
    byte unsigned v;
    v = blk[b / 8];
    return v[7 - (b % 8)];
  endfunction

  // CRC16 (x^16+x^12+x^5+1, init 0) of the bit stream carried on one lane.
  function automatic logic [15:0] lane_crc_ref(input bit wide, input int nbytes, input int lane);
    logic [15:0] crc;
    int          ncyc;
    bit          b;
    bit          fb;
    crc  = 16'h0;
    ncyc = wide ? nbytes * 2 : nbytes * 8;
    for (int c = 0; c < ncyc; c++) begin
      b   = wide ? data_bit(4 * c + 3 - lane) : data_bit(c);
      fb  = b ^ crc[15];
      crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return crc;
  endfunction

  // Full per-cycle line waveform: start, data, CRC (optionally corrupted), end (optionally bad).
  task automatic build_seq(input bit wide, input int nbytes, input int flip_lane,
                           input int flip_bit, input int end_bad_lane);
    logic [15:0] crc [4];
    logic [3:0]  v;
    seq.delete();
    for (int l = 0; l < 4; l++) crc[l] = lane_crc_ref(wide, nbytes, l);
    v = wide ? 4'h0 : {3'($urandom), 1'b0};
    seq.push_back(v);
    if (wide) begin
      for (int c = 0; c < nbytes * 2; c++) begin
        v = {data_bit(4 * c), data_bit(4 * c + 1), data_bit(4 * c + 2), data_bit(4 * c + 3)};
        seq.push_back(v);
      end
    end else begin
      for (int c = 0; c < nbytes * 8; c++) begin
        v = {3'($urandom), data_bit(c)};
        seq.push_back(v);
      end
    end
    for (int j = 0; j < 16; j++) begin
      v = 4'($urandom);
      for (int l = 0; l < 4; l++) begin
        if (wide || l == 0) v[l] = crc[l][15 - j] ^ ((l == flip_lane) && (j == flip_bit));
      end
      seq.push_back(v);
    end
    v = wide ? 4'hF : {3'($urandom), 1'b1};
    if (end_bad_lane >= 0) v[end_bad_lane] = 1'b0;
    seq.push_back(v);
  endtask

  task automatic observe(input bit big, output logic [31:0] w, output logic wv, output logic bz,
                         output logic cp, output logic ce, output logic ee);
    if (big) begin
      w = word_b; wv = wv_b; bz = busy_b; cp = comp_b; ce = crce_b; ee = ende_b;
    end else begin
      w = word_s; wv = wv_s; bz = busy_s; cp = comp_s; ce = crce_s; ee = ende_s;
    end
  endtask

  // Drive one block; abort_at >= 0 drops enable (or asserts reset) at that line cycle.
  task automatic run_block(input string name, input bit big, input bit wide, input int nbytes,
                           input int flip_lane, input int flip_bit, input int end_bad_lane,
                           input int abort_at, input bit abort_reset);
    int          last, stop, cpw, nwords, n_exp, k;
    int          wv_idx [$];
    logic [31:0] wv_word [$];
    int          comp_idx [$];
    logic [31:0] w, w_end, exp_word;
    logic        wv, bz, cp, ce, ee;
    logic        busy_first, busy_pre, busy_end, ce_end, ee_end, wv_end, cp_end;
    bit          exp_end, exp_crc;

    build_seq(wide, nbytes, flip_lane, flip_bit, end_bad_lane);
    last   = seq.size() - 1;
    stop   = (abort_at >= 0) ? abort_at : last;
    cpw    = wide ? 8 : 32;
    nwords = nbytes / 4;
    n_exp  = 0;
    for (int j = 1; j <= nwords; j++) if (j * cpw < stop) n_exp++;
    busy_first = 1'b0; busy_pre = 1'b1; busy_end = 1'b1;
    ce_end = 1'b1; ee_end = 1'b1; wv_end = 1'b1; cp_end = 1'b1; w_end = '1;

    @(negedge sd_clock);
    dat = seq[0]; bus_wide = wide; en_s = !big; en_b = big; reset = 1'b0;
    for (int i = 0; i <= stop + 3; i++) begin
      @(negedge sd_clock);
      observe(big, w, wv, bz, cp, ce, ee);
      if (wv) begin wv_idx.push_back(i); wv_word.push_back(w); end
      if (cp) comp_idx.push_back(i);
      if (i == 0) busy_first = bz;
      if (i == stop - 1) busy_pre = bz;
      if (i == stop) begin
        busy_end = bz; ce_end = ce; ee_end = ee; wv_end = wv; cp_end = cp; w_end = w;
      end
      if (i < stop) begin
        dat = seq[i + 1];
        bus_wide = 1'($urandom);
        if ((i + 1 == stop) && (abort_at >= 0)) begin
          if (abort_reset) reset = 1'b1;
          else begin en_s = 1'b0; en_b = 1'b0; end
        end
      end else begin
        dat = 4'hF; reset = 1'b0; en_s = !big; en_b = big;
      end
    end

    checks++;
    if (busy_first !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy_first);
    end
    checks++;
    if (wv_idx.size() != n_exp) begin
      errors++; $display("FAIL %s word_valid_count: got %0d want %0d", name, wv_idx.size(), n_exp);
    end
    k = 0;
    while ((k < n_exp) && (k < wv_idx.size())) begin
      exp_word = {blk[4 * k], blk[4 * k + 1], blk[4 * k + 2], blk[4 * k + 3]};
      checks++;
      if (wv_idx[k] != (k + 1) * cpw) begin
        errors++; $display("FAIL %s word%0d_cycle: got %0d want %0d", name, k, wv_idx[k], (k + 1) * cpw);
      end
      checks++;
      if (wv_word[k] !== exp_word) begin
        errors++; $display("FAIL %s word%0d_value: got %h want %h", name, k, wv_word[k], exp_word);
      end
      k++;
    end
    checks++;
    if (abort_at < 0) begin
      if ((comp_idx.size() != 1) || (comp_idx[0] != last)) begin
        errors++;
        $display("FAIL %s complete: got %0d pulses first at %0d want 1 pulse at %0d",
                 name, comp_idx.size(), (comp_idx.size() > 0) ? comp_idx[0] : -1, last);
      end
    end else if (comp_idx.size() != 0) begin
      errors++; $display("FAIL %s complete_after_abort: got %0d pulses want 0", name, comp_idx.size());
    end
    if (stop > 0) begin
      checks++;
      if (busy_pre !== 1'b1) begin
        errors++; $display("FAIL %s busy_before_end: got %b want 1", name, busy_pre);
      end
    end
    checks++;
    if (busy_end !== 1'b0) begin
      errors++; $display("FAIL %s busy_at_end: got %b want 0", name, busy_end);
    end

    if (abort_at < 0) begin
      exp_end = (end_bad_lane >= 0) && (wide || end_bad_lane == 0);
`ifdef SD_DAT_CRC_EN
      exp_crc = (flip_lane >= 0) && (wide || flip_lane == 0);
`else
      exp_crc = 1'b0;
`endif
      exp_word = {blk[nbytes - 4], blk[nbytes - 3], blk[nbytes - 2], blk[nbytes - 1]};
      checks++;
      if (w_end !== exp_word) begin
        errors++; $display("FAIL %s word_hold: got %h want %h", name, w_end, exp_word);
      end
      checks++;
      if (ee_end !== exp_end) begin
        errors++; $display("FAIL %s end_err: got %b want %b", name, ee_end, exp_end);
      end
      checks++;
      if (ce_end !== exp_crc) begin
        errors++; $display("FAIL %s crc_err: got %b want %b", name, ce_end, exp_crc);
      end
    end else if (abort_reset) begin
      checks++;
      if ({w_end, wv_end, cp_end, ce_end, ee_end} !== 37'h0) begin
        errors++;
        $display("FAIL %s outputs_after_reset: got word=%h wv=%b cp=%b ce=%b ee=%b want all 0",
                 name, w_end, wv_end, cp_end, ce_end, ee_end);
      end
    end else begin
      checks++;
      if ({ce_end, ee_end} !== 2'b00) begin
        errors++; $display("FAIL %s flags_after_abort: got ce=%b ee=%b want 0 0", name, ce_end, ee_end);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en_s = 1'b1; en_b = 1'b1; dat = 4'h0; bus_wide = 1'b1;
    repeat (3) @(negedge sd_clock);
    checks++;
    if ({word_s, wv_s, busy_s, comp_s, crce_s, ende_s} !== 37'h0) begin
      errors++; $display("FAIL reset_small: got word=%h wv=%b busy=%b want all 0", word_s, wv_s, busy_s);
    end
    checks++;
    if ({word_b, wv_b, busy_b, comp_b, crce_b, ende_b} !== 37'h0) begin
      errors++; $display("FAIL reset_big: got word=%h wv=%b busy=%b want all 0", word_b, wv_b, busy_b);
    end
    reset = 1'b0; en_s = 1'b0; en_b = 1'b0; dat = 4'hF;
    @(negedge sd_clock);
  endtask

  task automatic test_narrow_word();
    blk[0] = 8'hA5; blk[1] = 8'hA5; blk[2] = 8'h12; blk[3] = 8'h34;
    run_block("narrow_a5a51234", 1'b0, 1'b0, 4, -1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_wide_block();
    for (int i = 0; i < 512; i++) blk[i] = 8'(i);
    run_block("wide_512_incr", 1'b1, 1'b1, 512, -1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_crc_error();
    for (int i = 0; i < 4; i++) blk[i] = 8'($urandom);
    run_block("wide_crc_flip_dat2", 1'b0, 1'b1, 4, 2, $urandom_range(0, 15), -1, -1, 1'b0);
  endtask

  task automatic test_end_error();
    for (int i = 0; i < 4; i++) blk[i] = 8'($urandom);
    run_block("wide_end_bad_dat1", 1'b0, 1'b1, 4, -1, 0, 1, -1, 1'b0);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 4; i++) blk[i] = 8'($urandom);
    run_block("abort_data10", 1'b0, 1'b0, 4, -1, 0, -1, 10, 1'b0);
    for (int i = 0; i < 4; i++) blk[i] = 8'($urandom);
    run_block("after_abort", 1'b0, 1'b0, 4, -1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_reset_mid_crc();
    logic [3:0] partial [4];
    partial[0] = 4'h3; partial[1] = 4'h1; partial[2] = 4'hE; partial[3] = 4'h8;
    for (int i = 0; i < 4; i++) blk[i] = 8'($urandom);
    run_block("reset_mid_crc", 1'b0, 1'b0, 4, -1, 0, -1, 40, 1'b1);
    bus_wide = 1'b1; en_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dat = partial[i];
      @(negedge sd_clock);
      checks++;
      if (busy_s !== 1'b0) begin
        errors++; $display("FAIL partial_start_%h: got busy=%b want 0", partial[i], busy_s);
      end
    end
    dat = 4'hF;
    @(negedge sd_clock);
  endtask

  task automatic test_random_blocks();
    bit wide;
    int end_bad, flip;
    for (int n = 0; n < 6; n++) begin
      wide = 1'($urandom);
      for (int i = 0; i < 4; i++) blk[i] = 8'($urandom);
      end_bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      flip    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_block($sformatf("random%0d", n), 1'b0, wide, 4, flip, $urandom_range(0, 15), end_bad, -1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_narrow_word();
    test_wide_block();
    test_crc_error();
    test_end_error();
    test_abort();
    test_reset_mid_crc();
    test_random_blocks();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
